// File: rtl/operaters_checker_if.sv
// Sample bus between the operaters source and its receive-side checker.
// The master drives the sampled data and controls; the slave returns status.
interface operaters_checker_if #(
   parameter int unsigned ERR_W = 16
);
   logic [7:0]       pi_a;
   logic             pi_en;
   logic             pi_clr;
   logic             po_lock;
   logic             po_err;
   logic [ERR_W-1:0] po_err_cnt;
   logic [7:0]       po_max;

   modport master (
      output pi_a, pi_en, pi_clr,
      input  po_lock, po_err, po_err_cnt, po_max
   );

   modport slave (
      input  pi_a, pi_en, pi_clr,
      output po_lock, po_err, po_err_cnt, po_max
   );
endinterface

// File: rtl/operaters_checker.sv
// Receive-side checker: confirms the sampled bus advances by STEP (mod 256),
// locks after LOCK_CNT good steps, and flags/counts breaks while locked.
module operaters_checker #(
   parameter logic [7:0]  STEP     = 8'd1,
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned ERR_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   operaters_checker_if.slave bus
);

   localparam logic [ERR_W-1:0] CNT_MAX = '1;
   localparam logic [7:0]       LOCK_RUN = 8'(LOCK_CNT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HUNT = 2'd1,
      S_LOCK = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       a_prev_q, a_prev_d;
   logic [7:0]       run_q, run_d;
   logic [7:0]       max_q, max_d;
   logic             lock_q, lock_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] cnt_q, cnt_d;

   logic match_c;
   logic run_done_c;

   assign match_c    = (bus.pi_a == 8'(a_prev_q + STEP));
   assign run_done_c = (8'(run_q + 8'd1) == LOCK_RUN);

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         a_prev_q <= 8'd0;
         run_q    <= 8'd0;
         max_q    <= 8'd0;
         lock_q   <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_prev_q <= a_prev_d;
         run_q    <= run_d;
         max_q    <= max_d;
         lock_q   <= lock_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next-state logic; clear beats enable, disabled edges hold
   always_comb begin
      state_d = state_q;
      if (bus.pi_clr) begin
         state_d = S_IDLE;
      end else if (bus.pi_en) begin
         case (state_q)
            S_IDLE:  state_d = S_HUNT;
            S_HUNT:  if (match_c && run_done_c) state_d = S_LOCK;
            S_LOCK:  if (!match_c) state_d = S_HUNT;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Next values of the registered outputs and datapath
   always_comb begin
      a_prev_d = a_prev_q;
      run_d    = run_q;
      max_d    = max_q;
      lock_d   = lock_q;
      err_d    = 1'b0;
      cnt_d    = cnt_q;
      if (bus.pi_clr) begin
         a_prev_d = 8'd0;
         run_d    = 8'd0;
         max_d    = 8'd0;
         lock_d   = 1'b0;
         cnt_d    = '0;
      end else if (bus.pi_en) begin
         a_prev_d = bus.pi_a;
         max_d    = (bus.pi_a > max_q) ? bus.pi_a : max_q;
         lock_d   = (state_d == S_LOCK);
         case (state_q)
            S_IDLE: run_d = 8'd0;
            S_HUNT: begin
               if (match_c && !run_done_c) run_d = 8'(run_q + 8'd1);
               else                        run_d = 8'd0;
            end
            S_LOCK: begin
               if (!match_c) begin
                  err_d = 1'b1;
                  run_d = 8'd0;
                  if (cnt_q != CNT_MAX) cnt_d = ERR_W'(cnt_q + 1'b1);
               end
            end
            default: run_d = 8'd0;
         endcase
      end
   end

   assign bus.po_lock    = lock_q;
   assign bus.po_err     = err_q;
   assign bus.po_err_cnt = cnt_q;
   assign bus.po_max     = max_q;

endmodule
